// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: op codes, FSM states, widths and a flag helper.
package alu_seq_pkg;

    localparam int ALU_W     = 32;
    localparam int DIV_STEPS = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_MUL = 3'b100,
        ALU_DIV = 3'b101,
        ALU_POW = 3'b110,
        ALU_ILL = 3'b111
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_DIV_STEP = 3'd2,
        ST_POW_STEP = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // {N,Z,C,V} for results that do not come straight from the ALU.
    function automatic logic [3:0] nz_flags(input logic [ALU_W-1:0] v);
        return {v[ALU_W-1], (v == '0), 2'b00};
    endfunction

endpackage

// File: rtl/alu_seq_div_core.sv
// Restoring-division shift registers and bit-accept logic; the subtract happens in the shared ALU.
// ALU_SEQ_DIV_REM_EN exposes the remainder register as a port.
module alu_seq_div_core
    import alu_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [ALU_W-1:0] load_dvd,
    input  logic [ALU_W-1:0] load_rem,
    input  logic             step,
    input  logic [ALU_W-1:0] alu_result,
    input  logic             alu_c,
    output logic [ALU_W-1:0] sh,
    output logic [ALU_W-1:0] quot_next
`ifdef ALU_SEQ_DIV_REM_EN
    ,
    output logic [ALU_W-1:0] rem_out
`endif
);

    logic [ALU_W-1:0] rem;
    logic [ALU_W-1:0] dvd;
    logic [ALU_W-1:0] quot;
    logic             bit_ok;

    // rem[31] set means the shifted value is 33 bits wide and always exceeds the divisor.
    assign sh        = {rem[ALU_W-2:0], dvd[ALU_W-1]};
    assign bit_ok    = rem[ALU_W-1] | alu_c;
    assign quot_next = {quot[ALU_W-2:0], bit_ok};

`ifdef ALU_SEQ_DIV_REM_EN
    assign rem_out = rem;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem  <= '0;
            dvd  <= '0;
            quot <= '0;
        end else if (load) begin
            rem  <= load_rem;
            dvd  <= load_dvd;
            quot <= '0;
        end else if (step) begin
            rem  <= bit_ok ? alu_result : sh;
            dvd  <= {dvd[ALU_W-2:0], 1'b0};
            quot <= quot_next;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Request/response sequencer around the shared combinational ALU (simple ops, DIV, POW).
// ALU_SEQ_DIV_REM_EN adds the rsp_rem output carrying the division remainder.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int POW_EXP_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [ALU_W-1:0] req_a,
    input  logic [ALU_W-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ALU_W-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy,
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [ALU_W-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic [2:0]       dbg_state
`ifdef ALU_SEQ_DIV_REM_EN
    ,
    output logic [ALU_W-1:0] rsp_rem
`endif
);

    localparam int CNT_W = (POW_EXP_BITS > 5) ? POW_EXP_BITS : 5;

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
    // waits on ready, and a response holds result/flags stable until rsp_ready.
    state_t              state, state_nxt;
    op_t                 op_q;
    op_t                 req_op_e;
    logic [ALU_W-1:0]    a_q, b_q, acc_q, res_q;
    logic [3:0]          flg_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [POW_EXP_BITS-1:0] req_e;
    logic                accept;
    logic                op_simple;
    logic [ALU_W-1:0]    div_sh, div_quot_next;

    assign req_op_e  = op_t'(req_op);
    assign req_e     = req_b[POW_EXP_BITS-1:0];
    assign accept    = req_valid && req_ready;
    assign op_simple = (op_q <= ALU_MUL);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Zero-divisor, zero-exponent and illegal ops spend one cycle in EXEC with a preset result.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_op_e == ALU_DIV && req_b != '0)      state_nxt = ST_DIV_STEP;
                    else if (req_op_e == ALU_POW && req_e != '0) state_nxt = ST_POW_STEP;
                    else                                         state_nxt = ST_EXEC;
                end
            end
            ST_EXEC:     state_nxt = ST_DONE;
            ST_DIV_STEP: if (cnt_q == '0) state_nxt = ST_DONE;
            ST_POW_STEP: if (cnt_q == '0) state_nxt = ST_DONE;
            ST_DONE:     if (rsp_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE) && !reset;
        rsp_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = '0;
        case (state)
            ST_EXEC: begin
                if (op_simple) begin
                    alu_a    = a_q;
                    alu_b    = b_q;
                    alu_ctrl = op_q;
                end
            end
            ST_DIV_STEP: begin
                alu_a    = div_sh;
                alu_b    = b_q;
                alu_ctrl = ALU_SUB;
            end
            ST_POW_STEP: begin
                alu_a    = acc_q;
                alu_b    = a_q;
                alu_ctrl = ALU_MUL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= ALU_ADD;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            res_q <= '0;
            flg_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= req_op_e;
                        a_q   <= req_a;
                        b_q   <= req_b;
                        acc_q <= ALU_W'(1);
                        cnt_q <= (req_op_e == ALU_DIV) ? CNT_W'(DIV_STEPS - 1)
                                                       : CNT_W'(req_e) - CNT_W'(1);
                        if (req_op_e == ALU_POW) begin
                            res_q <= ALU_W'(1);
                            flg_q <= 4'b0000;
                        end else begin
                            res_q <= '0;
                            flg_q <= 4'b0100;
                        end
                    end
                end
                ST_EXEC: begin
                    if (op_simple) begin
                        res_q <= alu_result;
                        flg_q <= alu_flags;
                    end
                end
                ST_DIV_STEP: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        res_q <= div_quot_next;
                        flg_q <= nz_flags(div_quot_next);
                    end
                end
                ST_POW_STEP: begin
                    acc_q <= alu_result;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        res_q <= alu_result;
                        flg_q <= nz_flags(alu_result);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_result = res_q;
    assign rsp_flags  = flg_q;

    // A zero divisor preloads the dividend as remainder; every other accept clears it.
    alu_seq_div_core u_div_core (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_dvd   (req_a),
        .load_rem   ((req_op_e == ALU_DIV && req_b == '0) ? req_a : '0),
        .step       (state == ST_DIV_STEP),
        .alu_result (alu_result),
        .alu_c      (alu_flags[1]),
        .sh         (div_sh),
        .quot_next  (div_quot_next)
`ifdef ALU_SEQ_DIV_REM_EN
        ,
        .rem_out    (rsp_rem)
`endif
    );

endmodule
